// File: rtl/usb_wire_tx_fifo.sv
// usb_wire_tx_fifo
//   Transmit-side wire buffer between the SIE and the USB PHY. Symbols
//   {speed, TxBits, TxCtrl} are queued in a DEPTH-entry FIFO and drained one
//   per full-speed or low-speed bit tick, the rate being chosen per entry.
//   When the FIFO is empty the wire is released (00 / not driven) on every
//   tick of the rate of the last symbol sent.
//
//   Optional feature macro: USB_WIRE_TX_UNDERRUN_EN
//     defined   : sticky underrun flag, set when the FIFO runs dry while the
//                 wire is being actively driven, cleared by underrunClr
//                 (a coincident set wins).
//     undefined : underrun is tied 0 and underrunClr is ignored.
module usb_wire_tx_fifo #(
  parameter int DEPTH  = 4,
  parameter int FS_DIV = 4,
  parameter int LS_DIV = 32,
  localparam int LVL_W = $clog2(DEPTH) + 1,
  localparam int CNT_W = $clog2(LS_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       TxBitsIn,
  input  logic             TxCtrlIn,
  input  logic             fullSpeedRate,
  input  logic             USBWireWEn,
  output logic             USBWireRdy,
  output logic [1:0]       TxBitsOut,
  output logic             TxCtrlOut,
  output logic             TxDataOutTick,
  output logic             TxWireActiveDrive,
  output logic [LVL_W-1:0] fifoLevel,
  output logic             underrun,
  input  logic             underrunClr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int FS_W  = $clog2(FS_DIV);

  // Entry layout: [3] speed (1 = FS), [2:1] {D+,D-}, [0] drive enable
  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] level_nxt;
  logic [CNT_W-1:0] cnt;
  logic             fs_tick_p1;
  logic             ls_tick_p1;
  logic             last_rate;

  logic [3:0]       head;
  logic             not_empty;
  logic             rate;
  logic             sel_tick;
  logic             push;
  logic             pop;

  // Handshake and pop qualification, all derived from registered state
  assign head       = mem[rd_ptr];
  assign not_empty  = (level != '0);
  assign USBWireRdy = (level != LVL_W'(DEPTH));
  assign push       = USBWireWEn & USBWireRdy;
  // An empty FIFO keeps idling at the rate of the last symbol it sent
  assign rate       = not_empty ? head[3] : last_rate;
  assign sel_tick   = rate ? fs_tick_p1 : ls_tick_p1;
  assign pop        = sel_tick & not_empty;

  assign fifoLevel         = level;
  assign TxWireActiveDrive = TxCtrlOut;

  // Free-running bit-tick divider; tick flags are registered one cycle after the compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      fs_tick_p1 <= 1'b0;
      ls_tick_p1 <= 1'b0;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      fs_tick_p1 <= (cnt[FS_W-1:0] == '0);
      ls_tick_p1 <= (cnt == '0);
    end
  end

  // Storage array; every entry cleared on reset so no stale symbol survives it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 4'b0000;
      end
    end else if (push) begin
      mem[wr_ptr] <= {fullSpeedRate, TxBitsIn, TxCtrlIn};
    end
  end

  // Write and read pointers, wrapping naturally because DEPTH is a power of 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy update: a simultaneous push and pop cancel out
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Occupancy register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else begin
      level <= level_nxt;
    end
  end

  // Wire output stage: present the head symbol on each selected tick, or release the wire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TxBitsOut     <= 2'b00;
      TxCtrlOut     <= 1'b0;
      TxDataOutTick <= 1'b0;
      last_rate     <= 1'b0;
    end else if (sel_tick) begin
      TxDataOutTick <= ~TxDataOutTick;
      if (not_empty) begin
        TxBitsOut <= head[2:1];
        TxCtrlOut <= head[0];
        last_rate <= head[3];
      end else begin
        TxBitsOut <= 2'b00;
        TxCtrlOut <= 1'b0;
      end
    end
  end

`ifdef USB_WIRE_TX_UNDERRUN_EN
  logic underrun_q;

  // Sticky underrun: FIFO empty on a tick while the wire was still being driven
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= 1'b0;
    end else if (sel_tick && !not_empty && TxCtrlOut) begin
      underrun_q <= 1'b1;
    end else if (underrunClr) begin
      underrun_q <= 1'b0;
    end
  end

  assign underrun = underrun_q;
`else
  logic unused_underrun_clr;

  assign unused_underrun_clr = underrunClr;
  assign underrun            = 1'b0;
`endif

endmodule

// File: tb/tb_usb_wire_tx_fifo.sv
// Directed bench for usb_wire_tx_fifo with default parameters
// (DEPTH=4, FS_DIV=4, LS_DIV=32). Cycle numbers are posedges counted from
// reset release: FS ticks are consumed at edges 2,6,10,..., LS at 2,34,66,...
module tb_usb_wire_tx_fifo;

`ifdef USB_WIRE_TX_UNDERRUN_EN
  localparam logic EXP_UR = 1'b1;
`else
  localparam logic EXP_UR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] TxBitsIn;
  logic       TxCtrlIn;
  logic       fullSpeedRate;
  logic       USBWireWEn;
  logic       USBWireRdy;
  logic [1:0] TxBitsOut;
  logic       TxCtrlOut;
  logic       TxDataOutTick;
  logic       TxWireActiveDrive;
  logic [2:0] fifoLevel;
  logic       underrun;
  logic       underrunClr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [5:0] obs;
  logic [6:0] obs_r;

  assign obs   = {TxBitsOut, TxCtrlOut, fifoLevel};
  assign obs_r = {USBWireRdy, obs};

  usb_wire_tx_fifo dut (
    .clk               (clk),
    .rst               (rst),
    .TxBitsIn          (TxBitsIn),
    .TxCtrlIn          (TxCtrlIn),
    .fullSpeedRate     (fullSpeedRate),
    .USBWireWEn        (USBWireWEn),
    .USBWireRdy        (USBWireRdy),
    .TxBitsOut         (TxBitsOut),
    .TxCtrlOut         (TxCtrlOut),
    .TxDataOutTick     (TxDataOutTick),
    .TxWireActiveDrive (TxWireActiveDrive),
    .fifoLevel         (fifoLevel),
    .underrun          (underrun),
    .underrunClr       (underrunClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic drive_wr(input logic [1:0] bits, input logic ctrl, input logic fs);
    TxBitsIn      = bits;
    TxCtrlIn      = ctrl;
    fullSpeedRate = fs;
    USBWireWEn    = 1'b1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    USBWireWEn  = 1'b0;
    underrunClr = 1'b0;
    TxBitsIn    = 2'b00;
    TxCtrlIn    = 1'b0;
    fullSpeedRate = 1'b0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs_r !== 7'b1_00_0_000 || TxDataOutTick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy/bits/ctrl/lvl=%b tick=%b, want 1000000 tick=0", obs_r, TxDataOutTick);
    end
    step_to(1);
    n_checks++;
    if (TxDataOutTick !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_tick_c1: got %b want 0", TxDataOutTick);
    end
    step_to(2);
    n_checks++;
    if (TxDataOutTick !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_tick_c2: got %b want 1", TxDataOutTick);
    end
    step_to(33);
    n_checks++;
    if (TxDataOutTick !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_tick_c33: got %b want 1", TxDataOutTick);
    end
    step_to(34);
    n_checks++;
    if (TxDataOutTick !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_tick_c34: got %b want 0", TxDataOutTick);
    end
    step_to(65);
    n_checks++;
    if (TxDataOutTick !== 1'b0 || obs_r !== 7'b1_00_0_000) begin
      n_fail++;
      $display("FAIL idle_c65: tick=%b state=%b, want tick=0 state=1000000", TxDataOutTick, obs_r);
    end
    step_to(66);
    n_checks++;
    if (TxDataOutTick !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_tick_c66: got %b want 1", TxDataOutTick);
    end
  endtask

  task automatic test_fs_burst();
    do_reset();
    step_to(1);
    drive_wr(2'b10, 1'b1, 1'b1);
    step();
    drive_wr(2'b01, 1'b1, 1'b1);
    step();
    drive_wr(2'b10, 1'b1, 1'b1);
    step();
    drive_wr(2'b01, 1'b1, 1'b1);
    step();
    n_checks++;
    if (obs_r !== {1'b0, 2'b00, 1'b0, 3'd4}) begin
      n_fail++;
      $display("FAIL burst_full: got %b want 0000100", obs_r);
    end
    drive_wr(2'b11, 1'b0, 1'b1);
    step();
    USBWireWEn = 1'b0;
    n_checks++;
    if (obs_r !== {1'b1, 2'b10, 1'b1, 3'd3}) begin
      n_fail++;
      $display("FAIL burst_pop1: got %b want 1101011", obs_r);
    end
    step_to(10);
    n_checks++;
    if (obs_r !== {1'b1, 2'b01, 1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL burst_pop2: got %b want 1011010", obs_r);
    end
    step_to(14);
    n_checks++;
    if (obs_r !== {1'b1, 2'b10, 1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL burst_pop3: got %b want 1101001", obs_r);
    end
    step_to(18);
    n_checks++;
    if (obs_r !== {1'b1, 2'b01, 1'b1, 3'd0} || TxWireActiveDrive !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_pop4: got %b drv=%b want 1011000 drv=1", obs_r, TxWireActiveDrive);
    end
    step_to(22);
    n_checks++;
    if (obs_r !== {1'b1, 2'b00, 1'b0, 3'd0} || TxWireActiveDrive !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_drop_release: got %b drv=%b want 1000000 drv=0", obs_r, TxWireActiveDrive);
    end
  endtask

  task automatic test_mixed_rate();
    do_reset();
    step_to(2);
    drive_wr(2'b01, 1'b1, 1'b0);
    step();
    drive_wr(2'b10, 1'b1, 1'b1);
    step();
    USBWireWEn = 1'b0;
    n_checks++;
    if (obs !== {2'b00, 1'b0, 3'd2}) begin
      n_fail++;
      $display("FAIL mixed_queued: got %b want 000010", obs);
    end
    step_to(33);
    n_checks++;
    if (obs !== {2'b00, 1'b0, 3'd2}) begin
      n_fail++;
      $display("FAIL mixed_ls_wait: got %b want 000010", obs);
    end
    step_to(34);
    n_checks++;
    if (obs !== {2'b01, 1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL mixed_ls_out: got %b want 011001", obs);
    end
    step_to(37);
    n_checks++;
    if (obs !== {2'b01, 1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL mixed_ls_hold: got %b want 011001", obs);
    end
    step_to(38);
    n_checks++;
    if (obs !== {2'b10, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL mixed_fs_out: got %b want 101000", obs);
    end
    step_to(42);
    n_checks++;
    if (obs !== {2'b00, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL mixed_release: got %b want 000000", obs);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    do_reset();
    step_to(2);
    drive_wr(2'b10, 1'b1, 1'b1);
    step();
    drive_wr(2'b01, 1'b1, 1'b1);
    step();
    USBWireWEn = 1'b0;
    step_to(5);
    drive_wr(2'b11, 1'b1, 1'b1);
    step();
    USBWireWEn = 1'b0;
    n_checks++;
    if (obs !== {2'b10, 1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL pp_same_cycle: got %b want 101010", obs);
    end
    step_to(10);
    n_checks++;
    if (obs !== {2'b01, 1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL pp_order2: got %b want 011001", obs);
    end
    step_to(14);
    n_checks++;
    if (obs !== {2'b11, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL pp_order3: got %b want 111000", obs);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic bad;
    do_reset();
    step_to(1);
    drive_wr(2'b10, 1'b1, 1'b1);
    step();
    drive_wr(2'b01, 1'b1, 1'b1);
    step();
    drive_wr(2'b11, 1'b1, 1'b1);
    step();
    drive_wr(2'b01, 1'b1, 1'b1);
    step();
    USBWireWEn = 1'b0;
    step_to(6);
    n_checks++;
    if (obs !== {2'b10, 1'b1, 3'd3}) begin
      n_fail++;
      $display("FAIL rst_pre: got %b want 101011", obs);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs_r !== 7'b1_00_0_000) begin
      n_fail++;
      $display("FAIL rst_async: got %b want 1000000", obs_r);
    end
    do_reset();
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (TxCtrlOut !== 1'b0 || TxBitsOut !== 2'b00 || fifoLevel !== 3'd0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_stale: stale activity seen=%b want 0", bad);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    step_to(2);
    drive_wr(2'b10, 1'b1, 1'b1);
    step();
    USBWireWEn = 1'b0;
    step_to(6);
    n_checks++;
    if (obs !== {2'b10, 1'b1, 3'd0} || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ur_drive: got %b ur=%b want 101000 ur=0", obs, underrun);
    end
    step_to(10);
    n_checks++;
    if (obs !== {2'b00, 1'b0, 3'd0} || underrun !== EXP_UR) begin
      n_fail++;
      $display("FAIL ur_set: got %b ur=%b want 000000 ur=%b", obs, underrun, EXP_UR);
    end
    underrunClr = 1'b1;
    step();
    underrunClr = 1'b0;
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ur_clear: got %b want 0", underrun);
    end
    drive_wr(2'b01, 1'b1, 1'b1);
    step();
    USBWireWEn = 1'b0;
    step_to(14);
    n_checks++;
    if (obs !== {2'b01, 1'b1, 3'd0} || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ur_drive2: got %b ur=%b want 011000 ur=0", obs, underrun);
    end
    step_to(17);
    underrunClr = 1'b1;
    step();
    underrunClr = 1'b0;
    n_checks++;
    if (obs !== {2'b00, 1'b0, 3'd0} || underrun !== EXP_UR) begin
      n_fail++;
      $display("FAIL ur_set_wins: got %b ur=%b want 000000 ur=%b", obs, underrun, EXP_UR);
    end
    step();
    n_checks++;
    if (underrun !== EXP_UR) begin
      n_fail++;
      $display("FAIL ur_sticky: got %b want %b", underrun, EXP_UR);
    end
  endtask

  initial begin
    rst           = 1'b1;
    TxBitsIn      = 2'b00;
    TxCtrlIn      = 1'b0;
    fullSpeedRate = 1'b0;
    USBWireWEn    = 1'b0;
    underrunClr   = 1'b0;
    test_reset();
    test_fs_burst();
    test_mixed_rate();
    test_push_pop_same_cycle();
    test_reset_mid_drain();
    test_underrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
